process_control_n: RTL

//  Top-level session sequencer for the game board. Generalises the login -> menu -> app flow to NUM_APPS apps.

---
 rtl/pc_pkg.sv | 46 ++++
 rtl/pc_timer.sv | 27 ++
 rtl/process_control_n.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the session sequencer: FSM states, LCD/LED codes and
// helpers that size the select outputs and the shared timer.
package pc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AUTH    = 3'd1,
    ST_MSG     = 3'd2,
    ST_MENU    = 3'd3,
    ST_APP     = 3'd4,
    ST_LOCKOUT = 3'd5
  } pc_state_e;

  localparam logic [2:0] LCD_WELCOME    = 3'd0;
  localparam logic [2:0] LCD_ENTER_PW   = 3'd1;
  localparam logic [2:0] LCD_GRANTED    = 3'd2;
  localparam logic [2:0] LCD_INVALID    = 3'd3;
  localparam logic [2:0] LCD_APP_RUN    = 3'd4;
  localparam logic [2:0] LCD_MENU       = 3'd5;
  localparam logic [2:0] LCD_LOGGED_OUT = 3'd6;
  localparam logic [2:0] LCD_LOCKED     = 3'd7;

  localparam logic [1:0] LED_OFF   = 2'd0;
  localparam logic [1:0] LED_RED   = 2'd1;
  localparam logic [1:0] LED_GREEN = 2'd2;
  localparam logic [1:0] LED_AMBER = 2'd3;

  // buttons_select spans 1..NUM_APPS+2
  function automatic int bsel_w(input int num_apps);
    return $clog2(num_apps + 3);
  endfunction

  // app_select spans 0..NUM_APPS
  function automatic int asel_w(input int num_apps);
    return $clog2(num_apps + 1);
  endfunction

  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pc_timer.sv
// Loadable down-counter shared by the MSG, MENU and LOCKOUT states.
// Saturates at zero; zero flag is combinational from the count.
module pc_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/process_control_n.sv
// Session sequencer: login -> menu -> app flow with message hold, failed-login
// lockout and optional menu idle logout. Outputs are registered decodes of the next state.
module process_control_n
  import pc_pkg::*;
#(
  parameter int NUM_APPS       = 2,
  parameter int MAX_FAILS      = 3,
  parameter int MSG_HOLD       = 25000000,
  parameter int LOCKOUT_CYCLES = 250000000,
  parameter int IDLE_TIMEOUT   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_APPS:0]           buttons,
  input  logic                        access_control_fb,
  input  logic                        access_control_fail,
  input  logic [NUM_APPS-1:0]         app_done,
  output logic [bsel_w(NUM_APPS)-1:0] buttons_select,
  output logic                        switches_select,
  output logic [asel_w(NUM_APPS)-1:0] app_select,
  output logic [2:0]                  lcd_control,
  output logic [1:0]                  led_control,
  output logic                        access_control_reset
);

  localparam int BSEL_W = bsel_w(NUM_APPS);
  localparam int ASEL_W = asel_w(NUM_APPS);
  localparam int TW     = timer_w(MSG_HOLD, LOCKOUT_CYCLES, IDLE_TIMEOUT);
  localparam int FW     = $clog2(MAX_FAILS + 1);
  localparam bit IDLE_EN = (IDLE_TIMEOUT > 0);
  localparam logic [TW-1:0] LD_MSG  = TW'(MSG_HOLD - 1);
  localparam logic [TW-1:0] LD_LOCK = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] LD_IDLE = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  pc_state_e         state_reg, state_next;
  pc_state_e         msg_dest_reg, msg_dest_next;
  logic [NUM_APPS:0] btn_q_reg;
  logic [NUM_APPS:0] press;
  logic [FW-1:0]     fail_cnt_reg, fail_cnt_next;
  logic [ASEL_W-1:0] app_id_reg, app_id_next, menu_pick;
  logic [2:0]        msg_lcd_reg, msg_lcd_next;
  logic [1:0]        msg_led_reg, msg_led_next;

  logic [BSEL_W-1:0] bsel_reg, bsel_next;
  logic              swsel_reg, swsel_next;
  logic [ASEL_W-1:0] asel_reg, asel_next;
  logic [2:0]        lcd_reg, lcd_next;
  logic [1:0]        led_reg, led_next;
  logic              acr_reg, acr_next;

  logic              timer_load;
  logic [TW-1:0]     timer_val;
  logic              timer_zero;
  logic [NUM_APPS-1:0] app_active;
  logic              app_finished;

  assign press = buttons & ~btn_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_APPS; gi++) begin : g_app
      assign app_active[gi] = (app_id_reg == ASEL_W'(gi + 1));
    end
  endgenerate

  // Only the running app's done flag counts
  assign app_finished = |(app_done & app_active);

  // Ascending scan so the highest-indexed app button wins
  always_comb begin
    menu_pick = '0;
    for (int k = 0; k < NUM_APPS; k++) begin
      if (press[k+1]) menu_pick = ASEL_W'(k + 1);
    end
  end

  pc_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_val),
    .zero  (timer_zero)
  );

  always_comb begin
    state_next    = state_reg;
    msg_dest_next = msg_dest_reg;
    fail_cnt_next = fail_cnt_reg;
    app_id_next   = app_id_reg;
    msg_lcd_next  = msg_lcd_reg;
    msg_led_next  = msg_led_reg;
    timer_load    = 1'b0;
    timer_val     = '0;
    acr_next      = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (press[0]) state_next = ST_AUTH;
      end
      ST_AUTH: begin
        if (access_control_fb) begin
          fail_cnt_next = '0;
          msg_lcd_next  = LCD_GRANTED;
          msg_led_next  = LED_GREEN;
          msg_dest_next = ST_MENU;
          state_next    = ST_MSG;
          timer_load    = 1'b1;
          timer_val     = LD_MSG;
        end else if (access_control_fail) begin
          if (int'(fail_cnt_reg) + 1 >= MAX_FAILS) begin
            state_next = ST_LOCKOUT;
            timer_load = 1'b1;
            timer_val  = LD_LOCK;
          end else begin
            fail_cnt_next = fail_cnt_reg + 1'b1;
            msg_lcd_next  = LCD_INVALID;
            msg_led_next  = LED_RED;
            msg_dest_next = ST_AUTH;
            state_next    = ST_MSG;
            timer_load    = 1'b1;
            timer_val     = LD_MSG;
          end
        end
      end
      ST_MSG: begin
        if (timer_zero) begin
          state_next = msg_dest_reg;
          timer_load = 1'b1;
          timer_val  = LD_IDLE;
        end
      end
      ST_MENU: begin
        if (menu_pick != '0) begin
          app_id_next = menu_pick;
          state_next  = ST_APP;
        end else if (press[0] || (IDLE_EN && timer_zero)) begin
          acr_next      = 1'b0;
          fail_cnt_next = '0;
          msg_lcd_next  = LCD_LOGGED_OUT;
          msg_led_next  = LED_OFF;
          msg_dest_next = ST_IDLE;
          state_next    = ST_MSG;
          timer_load    = 1'b1;
          timer_val     = LD_MSG;
        end
      end
      ST_APP: begin
        if (app_finished) begin
          app_id_next = '0;
          state_next  = ST_MENU;
          timer_load  = 1'b1;
          timer_val   = LD_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (timer_zero) begin
          acr_next      = 1'b0;
          fail_cnt_next = '0;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        msg_dest_next = ST_IDLE;
        fail_cnt_next = '0;
        app_id_next   = '0;
      end
    endcase

    bsel_next  = BSEL_W'(1);
    swsel_next = 1'b0;
    asel_next  = '0;
    lcd_next   = LCD_WELCOME;
    led_next   = LED_OFF;
    case (state_next)
      ST_AUTH: begin
        bsel_next  = BSEL_W'(2);
        swsel_next = 1'b1;
        lcd_next   = LCD_ENTER_PW;
        led_next   = LED_RED;
      end
      ST_MSG: begin
        lcd_next = msg_lcd_next;
        led_next = msg_led_next;
      end
      ST_MENU: begin
        lcd_next = LCD_MENU;
        led_next = LED_GREEN;
      end
      ST_APP: begin
        bsel_next = BSEL_W'(int'(app_id_next) + 2);
        asel_next = app_id_next;
        lcd_next  = LCD_APP_RUN;
        led_next  = LED_GREEN;
      end
      ST_LOCKOUT: begin
        lcd_next = LCD_LOCKED;
        led_next = LED_AMBER;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      msg_dest_reg <= ST_IDLE;
      btn_q_reg    <= '1;
      fail_cnt_reg <= '0;
      app_id_reg   <= '0;
      msg_lcd_reg  <= LCD_WELCOME;
      msg_led_reg  <= LED_OFF;
      bsel_reg     <= BSEL_W'(1);
      swsel_reg    <= 1'b0;
      asel_reg     <= '0;
      lcd_reg      <= LCD_WELCOME;
      led_reg      <= LED_OFF;
      acr_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      msg_dest_reg <= msg_dest_next;
      btn_q_reg    <= buttons;
      fail_cnt_reg <= fail_cnt_next;
      app_id_reg   <= app_id_next;
      msg_lcd_reg  <= msg_lcd_next;
      msg_led_reg  <= msg_led_next;
      bsel_reg     <= bsel_next;
      swsel_reg    <= swsel_next;
      asel_reg     <= asel_next;
      lcd_reg      <= lcd_next;
      led_reg      <= led_next;
      acr_reg      <= acr_next;
    end
  end

  assign buttons_select       = bsel_reg;
  assign switches_select      = swsel_reg;
  assign app_select           = asel_reg;
  assign lcd_control          = lcd_reg;
  assign led_control          = led_reg;
  assign access_control_reset = acr_reg;

endmodule
